// File: rtl/rs_encoder.sv
// rs_encoder: systematic RS(255,239) encoder over GF(2^8), poly 0x11D, g(x) roots a^0..a^15.
//   clk_in      system clock
//   rst_n       asynchronous active-low reset
//   sync        high = idle/resync, low = frame running
//   data_in     message symbol, highest degree first
//   data_out    registered: 239 message symbols, then 16 parity symbols (x^15 first)
//   frame_start pulse with the first data_out symbol of a frame
//   enc_done    pulse with the last parity symbol of a frame
//   parity_flag (only with RS_ENC_PARITY_FLAG_EN) high while data_out carries parity
module rs_encoder (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic       sync,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       frame_start,
`ifdef RS_ENC_PARITY_FLAG_EN
  output logic       parity_flag,
`endif
  output logic       enc_done
);
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1d : 8'h00);
    end
    return p;
  endfunction
  // Expand prod (x + a^j), j = 0..15, at elaboration; g16 = 1 is implicit.
  function automatic logic [15:0][7:0] gen_poly();
    logic [16:0][7:0] g;
    logic [7:0] r;
    g = '0;
    g[0] = 8'h01;
    r = 8'h01;
    for (int j = 0; j < 16; j++) begin
      for (int i = 16; i > 0; i--) g[i] = g[i-1] ^ gf_mul(g[i], r);
      g[0] = gf_mul(g[0], r);
      r = gf_mul(r, 8'h02);
    end
    return g[15:0];
  endfunction
  localparam logic [15:0][7:0] g_coef = gen_poly();
  logic [7:0] cnt, fb;
  logic [15:0][7:0] par, sh, par_nxt;
  logic first, msg_ph;
  assign first = cnt == 8'd1;
  assign msg_ph = cnt != 8'd0 && cnt <= 8'd239;
  assign sh = {par[14:0], 8'h00};
  // At symbol 1 the previous remainder is ignored so frames never leak into each other.
  assign fb = data_in ^ (first ? 8'h00 : par[15]);
  always_comb begin
    par_nxt = '0;
    for (int j = 0; j < 16; j++)
      par_nxt[j] = cnt == 8'd0 ? 8'h00 : msg_ph ? (first ? 8'h00 : sh[j]) ^ gf_mul(fb, g_coef[j]) : sh[j];
  end
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      par <= '0;
      data_out <= '0;
      frame_start <= 1'b0;
      enc_done <= 1'b0;
`ifdef RS_ENC_PARITY_FLAG_EN
      parity_flag <= 1'b0;
`endif
    end else begin
      cnt <= sync ? 8'd0 : cnt == 8'd255 ? 8'd1 : cnt + 8'd1;
      par <= sync ? '0 : par_nxt;
      // A resync aborts the frame immediately, except that the final parity symbol still leaves.
      data_out <= (cnt == 8'd0 || (sync && cnt != 8'd255)) ? 8'h00 : msg_ph ? data_in : par[15];
      frame_start <= !sync && first;
      enc_done <= cnt == 8'd255;
`ifdef RS_ENC_PARITY_FLAG_EN
      parity_flag <= cnt >= 8'd240 && (!sync || cnt == 8'd255);
`endif
    end
  end
endmodule
